// File: rtl/tvip_axi_burst_beat_gen.sv
// Expands one AXI address-channel command into per-beat addresses, index, last and resp.
// Optional: TVIP_AXI_BURST_4KB_CHECK_EN flags INCR bursts that cross a 4 KB boundary.
module tvip_axi_burst_beat_gen #(
    parameter int ID_WIDTH      = 4,
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     aclk,
    input  logic                     areset_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [ID_WIDTH-1:0]      cmd_id,
    input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
    input  logic [7:0]               cmd_len,
    input  logic [2:0]               cmd_size,
    input  logic [1:0]               cmd_burst,
    output logic                     beat_valid,
    input  logic                     beat_ready,
    output logic [ID_WIDTH-1:0]      beat_id,
    output logic [ADDRESS_WIDTH-1:0] beat_addr,
    output logic [7:0]               beat_index,
    output logic                     beat_last,
    output logic [1:0]               beat_resp
);
    localparam int AW = ADDRESS_WIDTH;
    localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_WIDTH / 8));

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] BURST = 1'b1;

    localparam logic [1:0] FIXED = 2'b00;
    localparam logic [1:0] INCR  = 2'b01;
    localparam logic [1:0] WRAP  = 2'b10;

    logic [0:0] state;
    logic [7:0] len_q;
    logic [2:0] size_q;
    logic [1:0] mode_q;

    logic beat_fire;
    logic cmd_accept;

    logic [AW-1:0] c_bytes;
    logic [AW-1:0] c_aligned;
    logic [1:0]    c_mode;
    logic          c_err;
`ifdef TVIP_AXI_BURST_4KB_CHECK_EN
    logic [AW-1:0] c_span;
    logic [AW-1:0] c_end;
`endif

    logic [AW-1:0] cur_bytes;
    logic [AW-1:0] cur_aligned;
    logic [AW-1:0] cur_incr;
    logic [AW-1:0] cur_total;
    logic [AW-1:0] cur_bound;
    logic [AW-1:0] next_addr;

    assign beat_valid = (state == BURST);
    assign beat_fire  = beat_valid && beat_ready;
    assign cmd_ready  = areset_n && ((state == IDLE) || (beat_fire && beat_last));
    assign cmd_accept = cmd_valid && cmd_ready;

    // Error and effective addressing mode are fixed at acceptance time.
    always_comb begin
        c_bytes   = AW'(1) << cmd_size;
        c_aligned = cmd_addr & ~(c_bytes - AW'(1));
        c_mode    = cmd_burst;
        c_err     = (cmd_size > MAX_SIZE);
`ifdef TVIP_AXI_BURST_4KB_CHECK_EN
        c_span    = AW'({1'b0, cmd_len} + 9'd1) << cmd_size;
        c_end     = c_aligned + c_span - AW'(1);
`endif
        case (cmd_burst)
            2'b11: begin
                c_mode = INCR;
                c_err  = 1'b1;
            end
            WRAP: begin
                if (!(cmd_len inside {8'd1, 8'd3, 8'd7, 8'd15})) begin
                    c_mode = INCR;
                    c_err  = 1'b1;
                end else if (cmd_addr != c_aligned) begin
                    c_err  = 1'b1;
                end
            end
            INCR: begin
`ifdef TVIP_AXI_BURST_4KB_CHECK_EN
                if (c_aligned[AW-1:12] != c_end[AW-1:12])
                    c_err = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    always_comb begin
        cur_bytes   = AW'(1) << size_q;
        cur_aligned = beat_addr & ~(cur_bytes - AW'(1));
        cur_incr    = cur_aligned + cur_bytes;
        cur_total   = AW'({1'b0, len_q} + 9'd1) << size_q;
        cur_bound   = beat_addr & ~(cur_total - AW'(1));
        next_addr   = cur_incr;
        case (mode_q)
            FIXED: next_addr = beat_addr;
            WRAP: begin
                if (cur_incr == cur_bound + cur_total)
                    next_addr = cur_bound;
            end
            default: ;
        endcase
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state      <= IDLE;
            len_q      <= '0;
            size_q     <= '0;
            mode_q     <= '0;
            beat_id    <= '0;
            beat_addr  <= '0;
            beat_index <= '0;
            beat_last  <= 1'b0;
            beat_resp  <= 2'b00;
        end else if (cmd_accept) begin
            state      <= BURST;
            len_q      <= cmd_len;
            size_q     <= cmd_size;
            mode_q     <= c_mode;
            beat_id    <= cmd_id;
            beat_addr  <= cmd_addr;
            beat_index <= 8'd0;
            beat_last  <= (cmd_len == 8'd0);
            beat_resp  <= c_err ? 2'b10 : 2'b00;
        end else if (beat_fire) begin
            if (beat_last) begin
                state     <= IDLE;
                beat_last <= 1'b0;
            end else begin
                beat_addr  <= next_addr;
                beat_index <= beat_index + 8'd1;
                beat_last  <= (beat_index + 8'd1 == len_q);
            end
        end
    end
endmodule

// File: tb/tb_tvip_axi_burst_beat_gen.sv
// Directed bench for tvip_axi_burst_beat_gen (32-bit data, 32-bit address).
// Expected 4 KB response follows TVIP_AXI_BURST_4KB_CHECK_EN.
module tb_tvip_axi_burst_beat_gen;
    logic        aclk = 1'b0;
    logic        areset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_id;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [2:0]  cmd_size;
    logic [1:0]  cmd_burst;
    logic        beat_valid;
    logic        beat_ready;
    logic [3:0]  beat_id;
    logic [31:0] beat_addr;
    logic [7:0]  beat_index;
    logic        beat_last;
    logic [1:0]  beat_resp;

    int tests = 0;
    int fails = 0;

`ifdef TVIP_AXI_BURST_4KB_CHECK_EN
    localparam logic [1:0] KB_RESP = 2'b10;
`else
    localparam logic [1:0] KB_RESP = 2'b00;
`endif

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [1:0]  resp;
        logic [31:0] a [4];
    } vec_t;

    tvip_axi_burst_beat_gen dut (
        .aclk       (aclk),
        .areset_n   (areset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_id     (cmd_id),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .cmd_size   (cmd_size),
        .cmd_burst  (cmd_burst),
        .beat_valid (beat_valid),
        .beat_ready (beat_ready),
        .beat_id    (beat_id),
        .beat_addr  (beat_addr),
        .beat_index (beat_index),
        .beat_last  (beat_last),
        .beat_resp  (beat_resp)
    );

    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Presents a command at a negedge and returns at the negedge after the handshake.
    task automatic issue(input logic [3:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst);
        int n;
        cmd_id    = id;
        cmd_addr  = addr;
        cmd_len   = len;
        cmd_size  = size;
        cmd_burst = burst;
        cmd_valid = 1'b1;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            @(negedge aclk);
            n++;
        end
        tests++;
        if (n >= 20) begin
            fails++;
            $display("FAIL issue_timeout: cmd_ready=%b required 1", cmd_ready);
        end
        @(negedge aclk);
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        tests++;
        if (beat_valid !== 1'b0 || cmd_ready !== 1'b0 || beat_id !== 4'h0 ||
            beat_addr !== 32'h0 || beat_index !== 8'h0 || beat_last !== 1'b0 ||
            beat_resp !== 2'b00) begin
            fails++;
            $display("FAIL reset: v=%b rdy=%b id=%h a=%h i=%0d l=%b r=%b required all 0",
                     beat_valid, cmd_ready, beat_id, beat_addr, beat_index,
                     beat_last, beat_resp);
        end
        @(negedge aclk);
        areset_n = 1'b1;
        @(negedge aclk);
        tests++;
        if (cmd_ready !== 1'b1 || beat_valid !== 1'b0) begin
            fails++;
            $display("FAIL idle_after_reset: rdy=%b v=%b required 1 0",
                     cmd_ready, beat_valid);
        end
    endtask

    task automatic test_burst_table();
        vec_t vt [8];
        vt[0] = '{4'd1, 32'h34,   8'd3, 3'd2, 2'b10, 2'b00,
                  '{32'h34, 32'h38, 32'h3C, 32'h30}};
        vt[1] = '{4'd2, 32'h1001, 8'd2, 3'd2, 2'b01, 2'b00,
                  '{32'h1001, 32'h1004, 32'h1008, 32'h0}};
        vt[2] = '{4'd3, 32'h100,  8'd1, 3'd3, 2'b01, 2'b10,
                  '{32'h100, 32'h108, 32'h0, 32'h0}};
        vt[3] = '{4'd4, 32'h0,    8'd1, 3'd2, 2'b11, 2'b10,
                  '{32'h0, 32'h4, 32'h0, 32'h0}};
        vt[4] = '{4'd5, 32'hFF8,  8'd3, 3'd2, 2'b01, KB_RESP,
                  '{32'hFF8, 32'hFFC, 32'h1000, 32'h1004}};
        vt[5] = '{4'd6, 32'h40,   8'd2, 3'd2, 2'b10, 2'b10,
                  '{32'h40, 32'h44, 32'h48, 32'h0}};
        vt[6] = '{4'd7, 32'h10,   8'd0, 3'd2, 2'b01, 2'b00,
                  '{32'h10, 32'h0, 32'h0, 32'h0}};
        vt[7] = '{4'd8, 32'h35,   8'd3, 3'd2, 2'b10, 2'b10,
                  '{32'h35, 32'h38, 32'h3C, 32'h30}};
        beat_ready = 1'b1;
        for (int v = 0; v < 8; v++) begin
            issue(vt[v].id, vt[v].addr, vt[v].len, vt[v].size, vt[v].burst);
            for (int b = 0; b <= int'(vt[v].len); b++) begin
                tests++;
                if (beat_valid !== 1'b1 || beat_id !== vt[v].id ||
                    beat_addr !== vt[v].a[b] || beat_index !== 8'(b) ||
                    beat_last !== (b == int'(vt[v].len)) ||
                    beat_resp !== vt[v].resp) begin
                    fails++;
                    $display("FAIL vec%0d_beat%0d: v=%b id=%h a=%h i=%0d l=%b r=%b required 1 %h %h %0d %b %b",
                             v, b, beat_valid, beat_id, beat_addr, beat_index,
                             beat_last, beat_resp, vt[v].id, vt[v].a[b], b,
                             (b == int'(vt[v].len)), vt[v].resp);
                end
                @(negedge aclk);
            end
            tests++;
            if (beat_valid !== 1'b0) begin
                fails++;
                $display("FAIL vec%0d_end: beat_valid=%b required 0", v, beat_valid);
            end
        end
    endtask

    task automatic test_fixed_stall();
        logic [4:0] pat = 5'b10101;
        int done = 0;
        beat_ready = 1'b0;
        issue(4'd9, 32'h20, 8'd2, 3'd2, 2'b00);
        for (int k = 0; k < 5; k++) begin
            beat_ready = pat[k];
            tests++;
            if (beat_valid !== 1'b1 || beat_addr !== 32'h20 ||
                beat_index !== 8'(done) || beat_last !== (done == 2) ||
                beat_resp !== 2'b00) begin
                fails++;
                $display("FAIL fixed_cyc%0d: v=%b a=%h i=%0d l=%b r=%b required 1 20 %0d %b 00",
                         k, beat_valid, beat_addr, beat_index, beat_last,
                         beat_resp, done, (done == 2));
            end
            @(negedge aclk);
            if (pat[k]) done++;
        end
        tests++;
        if (beat_valid !== 1'b0) begin
            fails++;
            $display("FAIL fixed_end: beat_valid=%b required 0", beat_valid);
        end
    endtask

    task automatic test_back_to_back();
        beat_ready = 1'b1;
        issue(4'd3, 32'h200, 8'd1, 3'd2, 2'b01);
        tests++;
        if (beat_addr !== 32'h200 || beat_last !== 1'b0) begin
            fails++;
            $display("FAIL b2b_first: a=%h l=%b required 200 0", beat_addr, beat_last);
        end
        @(negedge aclk);
        cmd_id    = 4'hA;
        cmd_addr  = 32'h500;
        cmd_len   = 8'd1;
        cmd_size  = 3'd2;
        cmd_burst = 2'b01;
        cmd_valid = 1'b1;
        #1;
        tests++;
        if (cmd_ready !== 1'b1 || beat_last !== 1'b1 || beat_addr !== 32'h204) begin
            fails++;
            $display("FAIL b2b_ready: rdy=%b l=%b a=%h required 1 1 204",
                     cmd_ready, beat_last, beat_addr);
        end
        @(negedge aclk);
        cmd_valid = 1'b0;
        tests++;
        if (beat_valid !== 1'b1 || beat_id !== 4'hA || beat_addr !== 32'h500 ||
            beat_index !== 8'd0 || beat_last !== 1'b0) begin
            fails++;
            $display("FAIL b2b_second0: v=%b id=%h a=%h i=%0d l=%b required 1 a 500 0 0",
                     beat_valid, beat_id, beat_addr, beat_index, beat_last);
        end
        @(negedge aclk);
        tests++;
        if (beat_addr !== 32'h504 || beat_last !== 1'b1) begin
            fails++;
            $display("FAIL b2b_second1: a=%h l=%b required 504 1", beat_addr, beat_last);
        end
        @(negedge aclk);
        tests++;
        if (beat_valid !== 1'b0) begin
            fails++;
            $display("FAIL b2b_end: beat_valid=%b required 0", beat_valid);
        end
    endtask

    task automatic test_reset_mid_burst();
        beat_ready = 1'b1;
        issue(4'd5, 32'h300, 8'd3, 3'd2, 2'b01);
        @(negedge aclk);
        tests++;
        if (beat_index !== 8'd1 || beat_addr !== 32'h304) begin
            fails++;
            $display("FAIL midrst_pre: i=%0d a=%h required 1 304", beat_index, beat_addr);
        end
        areset_n = 1'b0;
        #1;
        tests++;
        if (beat_valid !== 1'b0 || cmd_ready !== 1'b0 || beat_addr !== 32'h0 ||
            beat_index !== 8'd0 || beat_last !== 1'b0 || beat_id !== 4'h0) begin
            fails++;
            $display("FAIL midrst_clear: v=%b rdy=%b a=%h i=%0d l=%b id=%h required 0 0 0 0 0 0",
                     beat_valid, cmd_ready, beat_addr, beat_index, beat_last, beat_id);
        end
        @(negedge aclk);
        areset_n = 1'b1;
        @(negedge aclk);
        tests++;
        if (beat_valid !== 1'b0 || cmd_ready !== 1'b1 || beat_last !== 1'b0) begin
            fails++;
            $display("FAIL midrst_idle: v=%b rdy=%b l=%b required 0 1 0",
                     beat_valid, cmd_ready, beat_last);
        end
    endtask

    initial begin
        areset_n   = 1'b0;
        cmd_valid  = 1'b0;
        cmd_id     = '0;
        cmd_addr   = '0;
        cmd_len    = '0;
        cmd_size   = '0;
        cmd_burst  = '0;
        beat_ready = 1'b0;
        #12;
        test_reset();
        test_burst_table();
        test_fixed_stall();
        test_back_to_back();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
